// File: rtl/oled_scene_sequencer.sv
// Scene sequencer for the 96x64 OLED: MENU/PLAY/PAUSE/RESULT with frame-aligned commits, x/y decode, pixel mux.
// Optional SCENE_BLANK_EN: blank oled_data for the full frame after each scene commit.
module oled_scene_sequencer #(
  parameter int BLINK_FRAMES   = 30,
  parameter int TIMEOUT_FRAMES = 180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        game_over,
  input  logic        game_won,
  input  logic [15:0] menu_data,
  input  logic [15:0] play_data,
  input  logic [15:0] pause_data,
  input  logic [15:0] result_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [1:0]  scene,
  output logic        result_won,
  output logic        blink_active,
  output logic [15:0] oled_data
);
  typedef enum logic [1:0] {MENU = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, RESULT = 2'd3} scene_t;
  typedef struct packed {
    logic   vld;
    scene_t tgt;
    logic   won;
  } req_t;

  scene_t      cur;
  req_t        pend, req;
  logic        start_q, pause_q, start_edge, pause_edge, adv, blank;
  logic [7:0]  blink_cnt;
  logic [9:0]  to_cnt;
  logic [12:0] rem;
  logic [5:0]  quo;
  logic        pix_ok, ok_q;
  scene_t      scene_q;
  logic [3:0][15:0] src;

  assign start_edge = btn_start & ~start_q;
  assign pause_edge = btn_pause & ~pause_q;
  assign scene      = cur;
  assign src        = {result_data, pause_data, play_data, menu_data};

`ifdef SCENE_BLANK_EN
  // The frame_begin that closes a blank frame does not count as a displayed frame.
  assign adv = frame_begin & ~blank;
`else
  assign blank = 1'b0;
  assign adv   = frame_begin;
`endif

  always_comb begin
    req = '0;
    unique case (cur)
      MENU:   if (start_edge) req = '{vld: 1'b1, tgt: PLAY, won: 1'b0};
      PLAY: begin
        if (game_over || game_won) req = '{vld: 1'b1, tgt: RESULT, won: game_won};
        else if (pause_edge)       req = '{vld: 1'b1, tgt: PAUSE, won: 1'b0};
      end
      PAUSE: begin
        if (start_edge)      req = '{vld: 1'b1, tgt: MENU, won: 1'b0};
        else if (pause_edge) req = '{vld: 1'b1, tgt: PLAY, won: 1'b0};
      end
      RESULT: if (start_edge || (frame_begin && to_cnt == 10'(TIMEOUT_FRAMES - 1)))
                req = '{vld: 1'b1, tgt: MENU, won: 1'b0};
      default: req = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur          <= MENU;
      pend         <= '0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      blink_cnt    <= '0;
      to_cnt       <= '0;
      blink_active <= 1'b0;
      result_won   <= 1'b0;
`ifdef SCENE_BLANK_EN
      blank        <= 1'b0;
`endif
    end else begin
      start_q <= btn_start;
      pause_q <= btn_pause;
      if (frame_begin && pend.vld) begin
        cur          <= pend.tgt;
        if (pend.tgt == RESULT) result_won <= pend.won;
        pend         <= '0;
        blink_cnt    <= '0;
        to_cnt       <= '0;
        blink_active <= 1'b0;
`ifdef SCENE_BLANK_EN
        blank        <= 1'b1;
`endif
      end else begin
        if (!pend.vld && req.vld) pend <= req;
`ifdef SCENE_BLANK_EN
        if (frame_begin) blank <= 1'b0;
`endif
        if (cur == PLAY || cur == PAUSE) begin
          blink_cnt    <= '0;
          blink_active <= 1'b0;
        end else if (adv) begin
          if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
            blink_cnt    <= '0;
            blink_active <= ~blink_active;
          end else begin
            blink_cnt <= blink_cnt + 8'd1;
          end
        end
        // Frozen once a request is pending; the commit clears it.
        if (cur == RESULT && adv && !pend.vld) to_cnt <= to_cnt + 10'd1;
      end
    end
  end

  // Restoring division by 96: one compare/subtract per quotient bit.
  always_comb begin
    rem = pixel_index;
    quo = '0;
    for (int k = 5; k >= 0; k--) begin
      if (rem >= (13'd96 << k)) begin
        rem    = rem - (13'd96 << k);
        quo[k] = 1'b1;
      end
    end
  end

  assign pix_ok = (pixel_index < 13'd6144);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      ok_q      <= 1'b0;
      scene_q   <= MENU;
      oled_data <= '0;
    end else begin
      x         <= pix_ok ? rem[6:0] : 7'd0;
      y         <= pix_ok ? quo : 6'd0;
      ok_q      <= pix_ok;
      scene_q   <= cur;
      oled_data <= (ok_q && !blank) ? src[scene_q] : 16'h0000;
    end
  end
endmodule

// File: tb/tb_oled_scene_sequencer.sv
// Bench for oled_scene_sequencer: coordinate table, directed scene sequences, random run against a frame-count model.
module tb_oled_scene_sequencer;
  localparam int B = 2;
  localparam int T = 5;

  logic        clk = 1'b0, rst_n = 1'b0, frame_begin = 1'b0;
  logic        btn_start = 1'b0, btn_pause = 1'b0, game_over = 1'b0, game_won = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [15:0] dc [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
  logic [6:0]  x;
  logic [5:0]  y;
  logic [1:0]  scene;
  logic        result_won, blink_active;
  logic [15:0] oled_data;

  oled_scene_sequencer #(.BLINK_FRAMES(B), .TIMEOUT_FRAMES(T)) dut (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .pixel_index(pixel_index),
    .btn_start(btn_start), .btn_pause(btn_pause), .game_over(game_over), .game_won(game_won),
    .menu_data(dc[0]), .play_data(dc[1]), .pause_data(dc[2]), .result_data(dc[3]),
    .x(x), .y(y), .scene(scene), .result_won(result_won), .blink_active(blink_active),
    .oled_data(oled_data)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;

  // Model: scene plus "frames shown since last commit"; blink and timeout derive from that count.
  int m_scene, m_pv, m_ps, m_pw, m_won, m_n, m_sq, m_pq, m_blank;
  int m_x, m_y, m_ok, m_sc1, m_oled;

  typedef struct {
    logic [12:0] idx;
    int          ex;
    int          ey;
    logic [15:0] eo;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_blink();
    return (m_scene == 0 || m_scene == 3) ? (m_n / B) % 2 : 0;
  endfunction

  task automatic model_reset();
    m_scene = 0; m_pv = 0; m_ps = 0; m_pw = 0; m_won = 0; m_n = 0; m_sq = 0; m_pq = 0;
    m_blank = 0; m_x = 0; m_y = 0; m_ok = 0; m_sc1 = 0; m_oled = 0;
  endtask

  task automatic model_step();
    int se, pe, rv, rs, rw, fb;
    fb = int'(frame_begin);
    se = int'(btn_start) & (m_sq ^ 1);
    pe = int'(btn_pause) & (m_pq ^ 1);
    rv = 0; rs = 0; rw = 0;
    case (m_scene)
      0: if (se != 0) begin rv = 1; rs = 1; end
      1: if (game_over || game_won) begin rv = 1; rs = 3; rw = int'(game_won); end
         else if (pe != 0) begin rv = 1; rs = 2; end
      2: if (se != 0) begin rv = 1; rs = 0; end
         else if (pe != 0) begin rv = 1; rs = 1; end
      default: if (se != 0 || (fb != 0 && m_n == T - 1)) begin rv = 1; rs = 0; end
    endcase
    m_oled = (m_ok != 0 && m_blank == 0) ? int'(dc[m_sc1]) : 0;
    m_ok   = (int'(pixel_index) < 6144) ? 1 : 0;
    m_x    = (m_ok != 0) ? int'(pixel_index) % 96 : 0;
    m_y    = (m_ok != 0) ? int'(pixel_index) / 96 : 0;
    m_sc1  = m_scene;
    if (fb != 0 && m_pv != 0) begin
      m_scene = m_ps;
      if (m_ps == 3) m_won = m_pw;
      m_pv = 0;
      m_n  = 0;
`ifdef SCENE_BLANK_EN
      m_blank = 1;
`endif
    end else begin
      if (m_pv == 0 && rv != 0) begin m_pv = 1; m_ps = rs; m_pw = rw; end
      if (fb != 0) begin
        if (m_blank == 0 && (m_scene == 0 || m_scene == 3)) m_n++;
        m_blank = 0;
      end
    end
    m_sq = int'(btn_start);
    m_pq = int'(btn_pause);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("x", int'(x), m_x);
    chk("y", int'(y), m_y);
    chk("scene", int'(scene), m_scene);
    chk("result_won", int'(result_won), m_won);
    chk("blink_active", int'(blink_active), m_blink());
    chk("oled_data", int'(oled_data), m_oled);
  endtask

  task automatic frame();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    repeat (5) tick();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_x"}, int'(x), 0);
    chk({nm, "_y"}, int'(y), 0);
    chk({nm, "_scene"}, int'(scene), 0);
    chk({nm, "_won"}, int'(result_won), 0);
    chk({nm, "_blink"}, int'(blink_active), 0);
    chk({nm, "_oled"}, int'(oled_data), 0);
  endtask

  initial begin
    int exp_blink [5] = '{0, 1, 1, 0, 0};
    tbl[0] = '{13'd0,    0,  0,  16'hA001};
    tbl[1] = '{13'd95,   95, 0,  16'hA001};
    tbl[2] = '{13'd96,   0,  1,  16'hA001};
    tbl[3] = '{13'd3071, 95, 31, 16'hA001};
    tbl[4] = '{13'd3072, 0,  32, 16'hA001};
    tbl[5] = '{13'd5000, 8,  52, 16'hA001};
    tbl[6] = '{13'd6143, 95, 63, 16'hA001};
    tbl[7] = '{13'd6144, 0,  0,  16'h0000};
    tbl[8] = '{13'd6150, 0,  0,  16'h0000};
    tbl[9] = '{13'd8191, 0,  0,  16'h0000};

    model_reset();
    pixel_index = 13'd1234;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      pixel_index = tbl[i].idx;
      tick();
      chk("tbl_x", int'(x), tbl[i].ex);
      chk("tbl_y", int'(y), tbl[i].ey);
      tick();
      chk("tbl_oled", int'(oled_data), int'(tbl[i].eo));
    end
    for (int p = 0; p < 6144; p++) begin
      pixel_index = 13'(p);
      tick();
    end
    pixel_index = 13'd100;

    btn_start = 1'b1; tick(); btn_start = 1'b0;
    repeat (3) tick();
    chk("start_wait_frame", int'(scene), 0);
    frame();
    chk("start_commit", int'(scene), 1);

    btn_pause = 1'b1;
    repeat (10) frame();
    chk("pause_held_single", int'(scene), 2);
    btn_pause = 1'b0; tick();

    btn_start = 1'b1; btn_pause = 1'b1; tick();
    btn_start = 1'b0; btn_pause = 1'b0; tick();
    frame();
    chk("pause_start_prio", int'(scene), 0);

    btn_start = 1'b1; frame_begin = 1'b1; tick();
    btn_start = 1'b0; frame_begin = 1'b0; tick();
    chk("req_on_fb_wait", int'(scene), 0);
    frame();
    chk("req_on_fb_commit", int'(scene), 1);

    game_won = 1'b1; btn_pause = 1'b1; tick();
    game_won = 1'b0; btn_pause = 1'b0; tick();
    frame();
    chk("won_over_pause", int'(scene), 3);
    chk("won_flag", int'(result_won), 1);

`ifndef SCENE_BLANK_EN
    for (int k = 0; k < 5; k++) begin
      frame();
      chk("result_scene", int'(scene), 3);
      chk("result_blink", int'(blink_active), exp_blink[k]);
    end
    frame();
    chk("timeout_commit", int'(scene), 0);
    chk("timeout_blink", int'(blink_active), 0);
    chk("won_kept", int'(result_won), 1);
`else
    btn_start = 1'b1; tick(); btn_start = 1'b0;
    pixel_index = 13'd10;
    frame();
    chk("blank_scene", int'(scene), 0);
    chk("blank_zero", int'(oled_data), 0);
    frame();
    chk("blank_end", int'(oled_data), int'(dc[0]));
`endif

    for (int c = 0; c < 4000; c++) begin
      frame_begin = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 19) == 0) btn_pause = ~btn_pause;
      game_over   = ($urandom_range(0, 29) == 0);
      game_won    = ($urandom_range(0, 29) == 0);
      pixel_index = 13'($urandom_range(0, 8191));
      tick();
    end
    frame_begin = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; game_over = 1'b0; game_won = 1'b0;
    repeat (3) tick();

    // Mid-cycle async reset, then a pending request lost to a second reset.
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    pixel_index = 13'd200;
    tick();
    btn_start = 1'b1; tick(); btn_start = 1'b0; tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_pending");
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    frame();
    chk("rst_no_commit", int'(scene), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
